// File: rtl/ps2_pkg.sv
// Shared constants and handshake state encoding for the PS/2 scan-code controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SETTLE,
    FLUSH
  } state_t;

endpackage

// File: rtl/ps2_prefix_timer.sv
// Abandons a dangling E0/F0 prefix: pulses expire after TIMEOUT_CYC idle cycles while active.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic active,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  assign expire = active && !restart && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart || !active || expire)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Pops the ps2_keyboard FIFO, decodes set-2 make/break/E0 sequences into held-key state.
// Optional prefix timeout is enabled by defining PS2_SCAN_TIMEOUT_EN.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic       kbd_clrn,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       key_event,
  output logic [7:0] key_count,
  output logic       ovf_seen
);

  state_t state, next_state;
  logic   ext_pend, brk_pend;
  logic   accept, enter_flush;
  logic   is_ext, is_brk, held_match, new_press;
  logic   pend_expire;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (kbd_overflow)
          next_state = FLUSH;
        else if (kbd_ready)
          next_state = ACK;
      end
      ACK:     next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered from next_state so they are glitch-free and align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_nextdata_n <= 1'b1;
      kbd_clrn       <= 1'b0;
    end else begin
      kbd_nextdata_n <= (next_state != ACK);
      kbd_clrn       <= (next_state != FLUSH);
    end
  end

  assign accept      = (state == IDLE) && !kbd_overflow && kbd_ready;
  assign enter_flush = (state == IDLE) && kbd_overflow;
  assign is_ext      = (kbd_data == PS2_EXT);
  assign is_brk      = (kbd_data == PS2_BRK);
  assign held_match  = (kbd_data == key_code) && (ext_pend == key_ext);
  assign new_press   = accept && !is_ext && !is_brk && !brk_pend && !(key_valid && held_match);

`ifdef PS2_SCAN_TIMEOUT_EN
  ps2_prefix_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_prefix_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .active (ext_pend || brk_pend),
    .expire (pend_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign pend_expire    = 1'b0;
`endif

  // A break only releases the held key when both code and E0-ness match; anything else is stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      key_event <= 1'b0;
      key_count <= 8'h00;
      ovf_seen  <= 1'b0;
    end else begin
      key_event <= new_press;
      if (pend_expire) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
      if (enter_flush) begin
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
        key_valid <= 1'b0;
        ovf_seen  <= 1'b1;
      end else if (accept) begin
        if (is_ext) begin
          ext_pend <= 1'b1;
        end else if (is_brk) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (brk_pend) begin
            if (held_match)
              key_valid <= 1'b0;
          end else if (new_press) begin
            key_code  <= kbd_data;
            key_ext   <= ext_pend;
            key_valid <= 1'b1;
            key_count <= key_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Controller that sequences the `ps2_keyboard` receive FIFO. It pops bytes through the `nextdata_n` handshake and recovers from FIFO overflow via `clrn`. It decodes PS/2 set-2 make, break and extended sequences (`E0`, `F0`) into a held-key state plus a debounced press counter. It sits between `ps2_keyboard` and the display/BCD path in the SoC top, replacing ad-hoc scan-code handling there.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 2_000_000: prefix-abandon timeout in clk cycles; used only with the timeout feature.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `kbd_data`  in  8  FIFO head byte from `ps2_keyboard`
- `kbd_ready`  in  1  FIFO non-empty
- `kbd_overflow`  in  1  FIFO overflow flag
- `kbd_nextdata_n`  out  1  active-low pop strobe to the FIFO
- `kbd_clrn`  out  1  active-low FIFO clear
- `key_code`  out  8  last pressed scan code (base byte)
- `key_ext`  out  1  last pressed key was `E0`-prefixed
- `key_valid`  out  1  a key is currently held
- `key_event`  out  1  one-cycle pulse on each new press
- `key_count`  out  8  number of new presses, wraps 255→0
- `ovf_seen`  out  1  sticky; set on overflow, cleared only by reset

Reset values: `kbd_nextdata_n`=1, `kbd_clrn`=0, all other outputs 0.

## Operation
Handshake FSM:
- `IDLE`:
  - If `kbd_overflow` → `FLUSH`. Overflow wins over `kbd_ready`.
  - Else if `kbd_ready` → capture `kbd_data`, run the decoder, go to `ACK`.
- `ACK`: `kbd_nextdata_n`=0 for exactly one cycle → `SETTLE`.
- `SETTLE`: `kbd_nextdata_n`=1, one cycle for the FIFO to update `ready` → `IDLE`.
- `FLUSH`: `kbd_clrn`=0 for one cycle.
  - Clears the `ext_pend` and `brk_pend` flags and `key_valid`, and sets `ovf_seen`.
  - `key_count`, `key_code` and `key_ext` are retained.
  - → `IDLE`.
- Outside `FLUSH` and reset, `kbd_clrn`=1.

Decoder, applied to the captured byte:
- `E0` → set `ext_pend`.
- `F0` → set `brk_pend`.
- Other byte with `brk_pend`=1 (break):
  - If byte==`key_code` and `ext_pend`==`key_ext`, clear `key_valid`.
  - Otherwise ignore, as a stale release.
  - Clear both pend flags.
- Other byte with `brk_pend`=0 (make):
  - If `key_valid` and byte/`ext_pend` match the held key → typematic repeat; no change except clearing flags.
  - Otherwise it is a new press:
    - load `key_code` and `key_ext`;
    - set `key_valid`;
    - increment `key_count`;
    - pulse `key_event`;
    - clear flags.
- A new press while another key is held replaces the held key. The earlier key's later break is then ignored as stale.

## Timing
- Byte accepted in `IDLE` at cycle N:
  - decoder registers update at the N edge and are visible at N+1;
  - `key_event` is high during N+1 only;
  - `kbd_nextdata_n` is low during N+1;
  - `IDLE` resumes at N+3.
- Throughput: one byte per 3 cycles.
- Overflow detected at N: `kbd_clrn` is low during N+1, back in `IDLE` at N+2.
- Reset mid-`ACK`: `kbd_nextdata_n` returns to 1 at the reset edge; the FIFO stays cleared while reset is held.
- `key_count` wraps from 255 to 0 silently.

## Configuration
- `PS2_SCAN_TIMEOUT_EN` defined:
  - a counter runs while `ext_pend` or `brk_pend` is set and restarts on every accepted byte;
  - on reaching `TIMEOUT_CYC-1` it clears both pend flags.
- Not defined: no counter, and pending prefixes persist indefinitely.
- Key state is never affected by the timeout.

## Structure
- Shared package `ps2_pkg`:
  - constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - FSM state encoding (`IDLE`, `ACK`, `SETTLE`, `FLUSH`).
- One sub-module, `ps2_prefix_timer`:
  - inputs: clk, reset, `restart`, `active`;
  - output: `expire` pulse;
  - instantiated only under `PS2_SCAN_TIMEOUT_EN`.
- Decoder and handshake FSM stay in `ps2_scan_ctrl`.

## Test plan
- Press/release: bytes 1C, F0, 1C.
  - `key_code`=1C, `key_valid`=1, `key_event` one pulse, `key_count`=1.
  - After the final 1C: `key_valid`=0, count still 1.
  - Each pop shows exactly one low cycle of `kbd_nextdata_n`.
- Typematic: 1C,1C,1C,1C, F0,1C → `key_count`=1, one `key_event`, `key_valid` 0 at end.
- Extended key: E0,75, E0,F0,75.
  - After the make: `key_ext`=1, `key_code`=75, count+1.
  - After the break: `key_valid`=0.
  - A plain 75 make afterwards counts as a new press.
- Overflow: assert `kbd_overflow` with `kbd_ready`=1 mid-sequence after F0.
  - One `kbd_clrn` low cycle, no pop, `ovf_seen`=1, `key_valid`=0.
  - The next 1C counts as a make, not a break.
- Wrap and stale release:
  - 256 distinct-alternating presses → `key_count`=0.
  - Sequence 1C,32,F0,1C → `key_code`=32, `key_valid` stays 1.
- Timeout, with `PS2_SCAN_TIMEOUT_EN` and `TIMEOUT_CYC`=16: F0, idle 20 cycles, then 1C → treated as a make, count+1.
